// File: rtl/monitor_pkg.sv
// Shared types and constants for the threshold monitor and its comparator.
package monitor_pkg;

    localparam int DATA_W = 4;

    localparam logic [DATA_W-1:0] MAX_RST = 4'h0;
    localparam logic [DATA_W-1:0] MIN_RST = 4'hF;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ALARM     = 2'd2,
        ST_DISARMING = 2'd3
    } monState_e;

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator; exactly one output is high at any time.
module comparator_4bit
    import monitor_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_gt_b,
    output logic              a_lt_b,
    output logic              a_eq_b
);

    assign a_gt_b = (a > b);
    assign a_lt_b = (a < b);
    assign a_eq_b = (a == b);

endmodule

// File: rtl/threshold_monitor_4bit.sv
// Tracks max/min/count of a 4-bit sample stream and raises a debounced,
// hysteretic over-threshold alarm.
module threshold_monitor_4bit
    import monitor_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              last_gt,
    output logic              last_lt,
    output logic              last_eq,
    output logic              alarm,
    output logic              alarm_rise
);

    localparam logic [3:0]       RUN_TGT = 4'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic cmpGt, cmpLt, cmpEq;

    comparator_4bit uCmp (
        .a      (in_data),
        .b      (threshold),
        .a_gt_b (cmpGt),
        .a_lt_b (cmpLt),
        .a_eq_b (cmpEq)
    );

    monState_e         state_q;
    logic [3:0]        runCnt_q;
    logic              alarm_q, alarmRise_q;

    logic [DATA_W-1:0] maxVal_q, maxVal_d;
    logic [DATA_W-1:0] minVal_q, minVal_d;
    logic [CNT_W-1:0]  sampleCnt_q, sampleCnt_d;
    logic              lastGt_q, lastGt_d;
    logic              lastLt_q, lastLt_d;
    logic              lastEq_q, lastEq_d;
    logic              seen_q, seen_d;

    // Run counter counts consecutive samples disagreeing with the current
    // alarm level; alarm and alarm_rise are decoded into flops alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OK;
            runCnt_q    <= 4'd0;
            alarm_q     <= 1'b0;
            alarmRise_q <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_OK;
            runCnt_q    <= 4'd0;
            alarm_q     <= 1'b0;
            alarmRise_q <= 1'b0;
        end else begin
            alarmRise_q <= 1'b0;
            if (in_valid) begin
                unique case (state_q)
                    ST_OK: begin
                        if (!cmpGt) begin
                            runCnt_q <= 4'd0;
                        end else if (RUN_LEN == 1) begin
                            state_q     <= ST_ALARM;
                            runCnt_q    <= 4'd0;
                            alarm_q     <= 1'b1;
                            alarmRise_q <= 1'b1;
                        end else begin
                            state_q  <= ST_ARMING;
                            runCnt_q <= 4'd1;
                        end
                    end
                    ST_ARMING: begin
                        if (!cmpGt) begin
                            state_q  <= ST_OK;
                            runCnt_q <= 4'd0;
                        end else if (runCnt_q + 4'd1 == RUN_TGT) begin
                            state_q     <= ST_ALARM;
                            runCnt_q    <= 4'd0;
                            alarm_q     <= 1'b1;
                            alarmRise_q <= 1'b1;
                        end else begin
                            runCnt_q <= runCnt_q + 4'd1;
                        end
                    end
                    ST_ALARM: begin
                        if (cmpGt) begin
                            runCnt_q <= 4'd0;
                        end else if (RUN_LEN == 1) begin
                            state_q  <= ST_OK;
                            runCnt_q <= 4'd0;
                            alarm_q  <= 1'b0;
                        end else begin
                            state_q  <= ST_DISARMING;
                            runCnt_q <= 4'd1;
                        end
                    end
                    ST_DISARMING: begin
                        if (cmpGt) begin
                            state_q  <= ST_ALARM;
                            runCnt_q <= 4'd0;
                        end else if (runCnt_q + 4'd1 == RUN_TGT) begin
                            state_q  <= ST_OK;
                            runCnt_q <= 4'd0;
                            alarm_q  <= 1'b0;
                        end else begin
                            runCnt_q <= runCnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q  <= ST_OK;
                        runCnt_q <= 4'd0;
                        alarm_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The first sample after reset/clear seeds both extremes.
    always_comb begin
        maxVal_d    = maxVal_q;
        minVal_d    = minVal_q;
        sampleCnt_d = sampleCnt_q;
        lastGt_d    = lastGt_q;
        lastLt_d    = lastLt_q;
        lastEq_d    = lastEq_q;
        seen_d      = seen_q;
        if (in_valid) begin
            lastGt_d = cmpGt;
            lastLt_d = cmpLt;
            lastEq_d = cmpEq;
            if (sampleCnt_q != CNT_MAX) begin
                sampleCnt_d = sampleCnt_q + CNT_ONE;
            end
            if (!seen_q) begin
                maxVal_d = in_data;
                minVal_d = in_data;
                seen_d   = 1'b1;
            end else begin
                if (in_data > maxVal_q) maxVal_d = in_data;
                if (in_data < minVal_q) minVal_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maxVal_q    <= MAX_RST;
            minVal_q    <= MIN_RST;
            sampleCnt_q <= '0;
            lastGt_q    <= 1'b0;
            lastLt_q    <= 1'b0;
            lastEq_q    <= 1'b0;
            seen_q      <= 1'b0;
        end else if (clear) begin
            maxVal_q    <= MAX_RST;
            minVal_q    <= MIN_RST;
            sampleCnt_q <= '0;
            lastGt_q    <= 1'b0;
            lastLt_q    <= 1'b0;
            lastEq_q    <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            maxVal_q    <= maxVal_d;
            minVal_q    <= minVal_d;
            sampleCnt_q <= sampleCnt_d;
            lastGt_q    <= lastGt_d;
            lastLt_q    <= lastLt_d;
            lastEq_q    <= lastEq_d;
            seen_q      <= seen_d;
        end
    end

    assign max_val    = maxVal_q;
    assign min_val    = minVal_q;
    assign sample_cnt = sampleCnt_q;
    assign last_gt    = lastGt_q;
    assign last_lt    = lastLt_q;
    assign last_eq    = lastEq_q;
    assign alarm      = alarm_q;
    assign alarm_rise = alarmRise_q;

endmodule
